dmux1t8_32_buf: RTL
===================

# dmux1t8_32_buf

Registered 1-to-8 distributor for 32-bit words: the write-side counterpart of the 8-to-1 selector used in the datapath. A producer presents one word per handshake; the block steers it into one of eight holding registers, addressed explicitly by a 3-bit select or by an internal round-robin pointer. Each register carries a full flag that its consumer clears with a per-channel acknowledge. It sits between a single result/write bus and eight independent downstream sinks, such as display channels or peripheral data latches.

## Interface
- WIDTH, 32, data width of the input word and of each holding register

- clk  in  1  system clock, all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  WIDTH  word to distribute
- s  in  3  explicit target channel, used when auto=0
- auto  in  1  1: target is the internal pointer ptr, s is ignored
- in_valid  in  1  producer has a word on din
- in_ready  out  1  block can accept into the current target this cycle (combinational)
- o0 … o7  out  WIDTH each  holding registers, channel 0…7
- o_valid  out  8  bit i = channel i holds an unconsumed word
- o_ack  in  8  bit i = consumer i takes its word this cycle
- ptr  out  3  round-robin pointer, the next auto target
- count  out  4  number of set bits in o_valid, registered, range 0–8

## Operation
- Target t = auto ? ptr : s.
- Ready rule: in_ready = ~o_valid[t] | o_ack[t]. A channel is writable when it is empty, or when it is full and acknowledged in the same cycle (pass-through).
- Accept occurs when in_valid & in_ready. On accept:
  - o_t <= din
  - o_valid[t] <= 1
  - if auto=1, ptr <= ptr+1, wrapping from 7 to 0
- Explicit-mode accepts (auto=0) never move ptr.
- Acknowledge:
  - o_ack[i] with o_valid[i]=1 and no same-cycle accept to channel i clears o_valid[i] next edge.
  - o_ack[i] with o_valid[i]=0 is ignored.
  - Multiple ack bits in one cycle are all honoured.
- Simultaneous accept to channel i and o_ack[i]: o_valid[i] stays 1 and o_i takes the new din.
- Data registers are not cleared by ack; they hold the last written value until overwritten or reset.
- Auto mode with ptr pointing at a full, unacked channel: in_ready=0 and the block stalls. It does not skip to another free channel. ptr is unchanged while stalled.
- Non-accepted cycles (in_valid=0 or in_ready=0) change nothing except ack-driven flag clears.
- count is next-state popcount of o_valid, registered alongside o_valid so the two always agree.
- Switching auto between cycles is legal; ptr keeps its value across explicit-mode periods.
- in_valid high with in_ready low is not an error. The producer holds din and s/auto stable until accepted; the block does not check this.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately without a clock edge):
  - o0…o7 = 0, o_valid = 8'h00, ptr = 0, count = 0
  - in_ready = 1 whenever in_valid is presented
- Reset release is sampled synchronously; the first accept can occur on the first rising edge with rst_n=1.
- Write latency: word accepted at edge N appears on o_t with o_valid[t]=1 after edge N, visible in cycle N+1.
- Ack latency: o_ack[i] sampled at edge N clears o_valid[i] after edge N.
- in_ready is combinational from s, auto, ptr, o_valid and o_ack. No combinational path from din or in_valid to in_ready.
- Throughput: one word per cycle, sustained while targets are free or acked in the same cycle.
- Reset asserted mid-stream discards all held words and the pointer; an in-flight handshake in that cycle is lost.

## Test plan
- Reset check: rst_n=0 pulse mid-cycle, no clock edge -> o0…o7=0, o_valid=00, ptr=0, count=0 immediately; in_ready=1.
- Explicit fill: auto=0, write 0xA0000000+i to s=i for i=0..7, one per cycle -> o_i=0xA0000000+i, o_valid=FF, count=8, ptr=0. Ninth write to s=3 -> in_ready=0, o3 unchanged.
- Auto wrap and stall: auto=1, 9 consecutive in_valid with din=1..9, no acks -> channels 0..7 hold 1..8, ptr wraps to 0, ninth word stalls with in_ready=0. o_ack=01 in the next cycle -> ninth word accepted into o0=9, ptr=1, count stays 8.
- Pass-through: channel 5 full with 0x55, write 0x66 to s=5 with o_ack=20 in the same cycle -> accepted, o5=0x66, o_valid[5]=1, count unchanged.
- Multi-ack and ignore: o_valid=0F, o_ack=FF -> o_valid=00 next cycle, count=0, o0..o3 retain their data.
- Reset mid-stream: auto=1, ptr=5, o_valid=1F, rst_n=0 during an accept cycle -> all outputs return to reset values; the accepted word is lost and ptr=0.

Source files
------------

// File: rtl/dmux1t8_32_buf.sv
// dmux1t8_32_buf
//   Registered 1-to-8 word distributor. One producer word per handshake is
//   steered into one of eight holding registers, chosen by an explicit
//   select (s) or by an internal round-robin pointer (ptr, when auto=1).
//   Each register carries a full flag cleared by its consumer's ack.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   din[WIDTH]        word to distribute
//   s[3], auto        explicit target / use round-robin pointer
//   in_valid,in_ready producer handshake (in_ready is combinational)
//   o0..o7[WIDTH]     holding registers
//   o_valid[8]        per-channel full flags
//   o_ack[8]          per-channel consumer acknowledge
//   ptr[3]            next auto-mode target
//   count[4]          popcount of o_valid, registered with it

// One holding register plus its full flag.
module dmux1t8_32_buf_chan #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             vld_d,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data_q,
  output logic             vld_q
);
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (wr_en) data_d = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end
endmodule

module dmux1t8_32_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       s,
  input  logic             auto,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [WIDTH-1:0] o5,
  output logic [WIDTH-1:0] o6,
  output logic [WIDTH-1:0] o7,
  output logic [7:0]       o_valid,
  input  logic [7:0]       o_ack,
  output logic [2:0]       ptr,
  output logic [3:0]       count
);
  localparam int NUM_LANES = 8;

  logic [NUM_LANES-1:0][WIDTH-1:0] data_q;
  logic [NUM_LANES-1:0]            vld_q;
  logic [NUM_LANES-1:0]            vld_d;
  logic [NUM_LANES-1:0]            wr_sel;
  logic [2:0]                      tgt;
  logic                            accept;
  logic [2:0]                      ptr_q, ptr_d;
  logic [3:0]                      count_q, count_d;

  // Ready depends only on target state and ack, never on din/in_valid.
  assign tgt      = auto ? ptr_q : s;
  assign in_ready = ~vld_q[tgt] | o_ack[tgt];
  assign accept   = in_valid & in_ready;

  always_comb begin
    wr_sel = '0;
    if (accept) wr_sel[tgt] = 1'b1;
    // A write wins over a same-cycle ack on the same channel.
    vld_d = wr_sel | (vld_q & ~o_ack);
    ptr_d = ptr_q;
    if (accept && auto) ptr_d = ptr_q + 3'd1;
    // count tracks the next-state flags so it always matches o_valid.
    count_d = '0;
    for (int i = 0; i < NUM_LANES; i++) count_d = count_d + {3'b000, vld_d[i]};
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_chan
    dmux1t8_32_buf_chan #(.WIDTH(WIDTH)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_sel[g]),
      .vld_d  (vld_d[g]),
      .din    (din),
      .data_q (data_q[g]),
      .vld_q  (vld_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign o0      = data_q[0];
  assign o1      = data_q[1];
  assign o2      = data_q[2];
  assign o3      = data_q[3];
  assign o4      = data_q[4];
  assign o5      = data_q[5];
  assign o6      = data_q[6];
  assign o7      = data_q[7];
  assign o_valid = vld_q;
  assign ptr     = ptr_q;
  assign count   = count_q;
endmodule
